// File: rtl/alu_cmd_issuer.sv
// Command issuer: queues ALU commands in a FIFO, drives an external combinational ALU, returns results.
// Latency: command accepted into an idle block appears on rsp_valid two cycles later; one response per 2 cycles.
// Backpressure: cmd_ready drops while the FIFO is full; rsp_* hold stable until rsp_ready.
// Optional accumulator operand source: define ALU_CMD_ISSUER_ACC_EN.
module alu_cmd_issuer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_opcode,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_c,
    input  logic        cmd_use_acc,
    output logic [2:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_c,
    input  logic [15:0] alu_w,
    input  logic        alu_zero,
    input  logic        alu_negative,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_w,
    output logic        rsp_zero,
    output logic        rsp_negative,
    output logic        rsp_illegal,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        use_acc;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    cmd_t           mem [DEPTH];
    cmd_t           cmd_in;
    cmd_t           head;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           full, empty;
    logic           push, pop;
    logic           capture, rsp_clr;
    logic [15:0]    a_sel;

    assign cmd_in.opcode  = cmd_opcode;
    assign cmd_in.a       = cmd_a;
    assign cmd_in.b       = cmd_b;
    assign cmd_in.c       = cmd_c;
    assign cmd_in.use_acc = cmd_use_acc;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || !empty;

    // Storage is not reset; count/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = DRIVE;
            DRIVE:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = empty ? IDLE : DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        rsp_clr = 1'b0;
        case (state)
            IDLE:  pop = !empty;
            DRIVE: capture = 1'b1;
            RESP: begin
                rsp_clr = rsp_ready;
                pop     = rsp_ready && !empty;
            end
            default: ;
        endcase
    end

`ifdef ALU_CMD_ISSUER_ACC_EN
    logic [15:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       acc <= '0;
        else if (capture) acc <= alu_w;
    end

    assign a_sel = head.use_acc ? acc : head.a;
`else
    logic unused_use_acc;
    assign unused_use_acc = head.use_acc;
    assign a_sel = head.a;
`endif

    // alu_* only change on pop, so they keep the last issued command while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_c      <= 1'b0;
        end else if (pop) begin
            alu_opcode <= head.opcode;
            alu_a      <= a_sel;
            alu_b      <= head.b;
            alu_c      <= head.c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_w        <= '0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
            rsp_illegal  <= 1'b0;
        end else if (capture) begin
            rsp_valid    <= 1'b1;
            rsp_w        <= alu_w;
            rsp_zero     <= alu_zero;
            rsp_negative <= alu_negative;
            rsp_illegal  <= (alu_opcode == 3'd7);
        end else if (rsp_clr) begin
            rsp_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: models the external ALU and scoreboards responses in acceptance order.
// Latency/throughput/full/reset behaviour checked by directed steps; define ALU_CMD_ISSUER_ACC_EN to match the DUT build.
module tb_alu_cmd_issuer;

    localparam int DEPTH = 4;
`ifdef ALU_CMD_ISSUER_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic        cmd_c = 1'b0;
    logic        cmd_use_acc = 1'b0;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_a, alu_b;
    logic        alu_c;
    logic [15:0] alu_w;
    logic        alu_zero, alu_negative;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_w;
    logic        rsp_zero, rsp_negative, rsp_illegal;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int rsp_cyc [$];
    logic [15:0] last_w = '0;
    logic [15:0] acc_m = '0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        ua;
    } cmd_s;
    cmd_s sbq [$];

    alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_use_acc(cmd_use_acc),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_w(alu_w), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_w(rsp_w), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative), .rsp_illegal(rsp_illegal),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                           input logic c);
        case (op)
            3'd0:    return 16'd0 - a;
            3'd1:    return a + 16'd1;
            3'd2:    return a + b + {15'd0, c};
            3'd3:    return a - b;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a ^ b;
            default: return 16'd0;
        endcase
    endfunction

    always_comb begin
        alu_w        = alu_fn(alu_opcode, alu_a, alu_b, alu_c);
        alu_zero     = (alu_w == 16'd0);
        alu_negative = alu_w[15];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: accepted commands queued, each handshaken response compared against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            acc_m = '0;
        end else begin
            if (cmd_valid && cmd_ready)
                sbq.push_back('{cmd_opcode, cmd_a, cmd_b, cmd_c, cmd_use_acc});
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    cmd_s e;
                    logic [15:0] a_eff, w;
                    e = sbq.pop_front();
                    a_eff = (ACC && e.ua) ? acc_m : e.a;
                    w = alu_fn(e.op, a_eff, e.b, e.c);
                    chk("rsp_w", 32'(rsp_w), 32'(w));
                    chk("rsp_zero", 32'(rsp_zero), 32'(w == 16'd0));
                    chk("rsp_negative", 32'(rsp_negative), 32'(w[15]));
                    chk("rsp_illegal", 32'(rsp_illegal), 32'(e.op == 3'd7));
                    acc_m = w;
                end
                last_w = rsp_w;
                rsp_cnt++;
                rsp_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic ua);
        cmd_opcode  = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_c       = c;
        cmd_use_acc = ua;
        cmd_valid   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (!cmd_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) break;
        end
        if (busy || rsp_valid) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int base;

        // reset state
        #2;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_rsp_w", 32'(rsp_w), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // add with carry, latency two edges after acceptance
        send(3'd2, 16'h0005, 16'h0003, 1'b1, 1'b0);
        @(negedge clk);
        chk("lat_n0", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_n1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_n2", 32'(rsp_valid), 32'd1);
        chk("add_w", 32'(rsp_w), 32'h0009);
        wait_idle();
        chk("hold_alu_opcode", 32'(alu_opcode), 32'd2);
        chk("hold_alu_a", 32'(alu_a), 32'h0005);
        chk("hold_alu_b", 32'(alu_b), 32'h0003);

        // negate, illegal opcode, and a few more ops back to back
        @(posedge clk);
        #1;
        send(3'd0, 16'h0001, 16'h0000, 1'b0, 1'b0);
        send(3'd7, 16'h1234, 16'h5678, 1'b1, 1'b0);
        send(3'd3, 16'h0003, 16'h0005, 1'b0, 1'b0);
        send(3'd4, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0);
        send(3'd5, 16'h8000, 16'h0001, 1'b0, 1'b0);
        send(3'd6, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0);
        wait_idle();
        chk("illegal_cleared_w", 32'(rsp_cnt), 32'd7);

        // fill: five accepted (four queued plus one in flight), then drain in order
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        accepted = 0;
        for (int cy = 0; cy < 6; cy++) begin
            cmd_opcode  = 3'd2;
            cmd_a       = 16'h0100 + 16'(accepted);
            cmd_b       = 16'(accepted);
            cmd_c       = 1'b0;
            cmd_use_acc = 1'b0;
            cmd_valid   = 1'b1;
            @(negedge clk);
            if (cmd_ready) accepted++;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("full_accepted", 32'(accepted), 32'd5);
        @(negedge clk);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall_rsp_w", 32'(rsp_w), 32'h0100);
        base = rsp_cnt;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_cnt >= base + 5) break;
        end
        chk("drain_count", 32'(rsp_cnt - base), 32'd5);
        for (int i = 1; i < 5; i++)
            chk("drain_gap", 32'(rsp_cyc[base+i] - rsp_cyc[base+i-1]), 32'd2);
        wait_idle();

        // reset while in RESP with three commands queued
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(3'd1, 16'h0200 + 16'(i), 16'h0000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pre_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_rsp_w", 32'(rsp_w), 32'd0);
        base = rsp_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_no_rsp", 32'(rsp_cnt), 32'(base));
        chk("post_rst_busy", 32'(busy), 32'd0);

        // accumulator operand source
        @(posedge clk);
        #1;
        send(3'd1, 16'h0010, 16'h0000, 1'b0, 1'b0);
        wait_idle();
        chk("acc_first", 32'(last_w), 32'h0011);
        @(posedge clk);
        #1;
        send(3'd1, 16'h0000, 16'h0000, 1'b0, 1'b1);
        wait_idle();
        chk("acc_second", 32'(last_w), ACC ? 32'h0012 : 32'h0001);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, command FIFO depth (power of 2, 2..16).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: cmd_valid input 1, cmd_ready output 1  command handshake.
REQ-005 SHALL have ports: cmd_opcode input 3, cmd_a input 16, cmd_b input 16, cmd_c input 1, cmd_use_acc input 1  command payload.
REQ-006 SHALL have ports: alu_opcode output 3, alu_a output 16, alu_b output 16, alu_c output 1  registered drive to the combinational 16-bit ALU.
REQ-007 SHALL have ports: alu_w input 16, alu_zero input 1, alu_negative input 1  ALU result and flags.
REQ-008 SHALL have ports: rsp_valid output 1, rsp_ready input 1  response handshake.
REQ-009 SHALL have ports: rsp_w output 16, rsp_zero output 1, rsp_negative output 1, rsp_illegal output 1  response payload.
REQ-010 SHALL have port: busy output 1  high when FSM not IDLE or FIFO non-empty.

Function
REQ-011 SHALL buffer commands in a DEPTH-entry FIFO; push on cmd_valid&&cmd_ready; cmd_ready = !full.
REQ-012 SHALL never push when full; cmd_valid while full is held off by the sender (no drop, no overwrite).
REQ-013 SHALL use FSM states IDLE, DRIVE, RESP.
REQ-014 IDLE: FIFO non-empty -> pop head, load alu_* registers, go DRIVE; else stay.
REQ-015 DRIVE: lasts exactly one cycle; at its end capture alu_w/alu_zero/alu_negative into rsp_* and set rsp_valid, go RESP.
REQ-016 RESP: hold rsp_* stable while rsp_valid&&!rsp_ready; on handshake with FIFO non-empty pop directly and go DRIVE; with FIFO empty clear rsp_valid and go IDLE.
REQ-017 Latency: idle block, empty FIFO, command accepted at edge N -> rsp_valid high after edge N+2.
REQ-018 Sustained throughput: one response per 2 cycles with rsp_ready held high.
REQ-019 Responses SHALL appear in command acceptance order.
REQ-020 alu_* outputs SHALL hold the last issued command between operations.
REQ-021 rsp_illegal SHALL be 1 for opcode 3'd7, else 0; rsp_w/flags still passed from the ALU unmodified.
REQ-022 Push and pop in the same cycle SHALL both take effect; FIFO count unchanged.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; full/empty distinguished by an extra pointer bit or count.

Reset
REQ-024 rst_n low SHALL immediately clear FSM to IDLE, FIFO to empty, rsp_valid=0, rsp_w=0, rsp_zero=0, rsp_negative=0, rsp_illegal=0, alu_opcode=0, alu_a=0, alu_b=0, alu_c=0, busy=0.
REQ-025 Reset mid-operation SHALL discard in-flight and queued commands with no response emitted.
REQ-026 cmd_ready SHALL be 1 during and after reset.

Configuration
REQ-027 Macro ALU_CMD_ISSUER_ACC_EN defined: 16-bit accumulator, reset 0, loaded with alu_w at every DRIVE capture; pop with cmd_use_acc=1 drives alu_a from accumulator instead of cmd_a.
REQ-028 Macro undefined: no accumulator, cmd_use_acc ignored, alu_a always cmd_a.

Verification
REQ-029 opcode 2, a=0x0005, b=0x0003, c=1, idle -> rsp_valid after edge N+2, rsp_w=0x0009, zero=0, negative=0, illegal=0.
REQ-030 opcode 0, a=0x0001 -> rsp_w=0xFFFF, negative=1, zero=0.
REQ-031 DEPTH=4, rsp_ready=0, six back-to-back commands -> exactly five accepted, cmd_ready low; rsp_ready=1 -> five responses in order, 2 cycles apart.
REQ-032 opcode 7, any operands -> rsp_w=0x0000, zero=1, illegal=1.
REQ-033 rst_n pulsed low while in RESP with 3 queued -> rsp_valid=0, busy=0, cmd_ready=1 immediately; no response after release.
REQ-034 ACC_EN defined: opcode 1 a=0x0010 -> 0x0011; then opcode 1 use_acc=1 a=0x0000 -> 0x0012; undefined: second -> 0x0001.
